// File: rtl/pl_rv32_decode_stage.sv
// pl_rv32_decode_stage: RV32 decode into a registered ID/EX control bundle with load-use stall, flush and divide sequencing
module pl_rv32_decode_stage #(
  parameter bit ENABLE_M   = 1'b0,
  parameter int DIV_CYCLES = 32,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_instr,
  input  logic        flush,
  input  logic        csr_illegal_access,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [4:0]  ex_alu_op,
  output logic [1:0]  ex_src_a_sel,
  output logic        ex_src_b_sel,
  output logic [2:0]  ex_imm_sel,
  output logic [1:0]  ex_wb_sel,
  output logic        ex_reg_write_en,
  output logic        ex_mem_read_en,
  output logic        ex_mem_write_en,
  output logic        ex_csr_write_en,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [11:0] ex_csr_addr,
  output logic        ex_illegal
);
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
                         ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
                         ALU_PASS_B = 5'd10, ALU_MUL = 5'd11, ALU_DIV = 5'd15;
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t state;
  logic [5:0] cnt;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [4:0] d_alu;
  logic [1:0] d_src_a, d_wb;
  logic       d_src_b, d_rw, d_mr, d_mw, d_cw, d_illegal, use1, use2;
  logic [2:0] d_imm;
  logic       hazard, accept, is_div;
  assign opc = id_instr[6:0];
  assign rd  = id_instr[11:7];
  assign f3  = id_instr[14:12];
  assign rs1 = id_instr[19:15];
  assign rs2 = id_instr[24:20];
  assign f7  = id_instr[31:25];
  function automatic logic [4:0] alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_SLT;
      3'd3:    alu_of = ALU_SLTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction
  always_comb begin
    d_illegal = 1'b1;
    d_alu     = ALU_ADD;
    d_src_a   = 2'd0;
    d_src_b   = 1'b0;
    d_imm     = 3'd0;
    d_wb      = 2'd0;
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_cw      = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    case (opc)
      7'h03: if (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7) begin
        d_illegal = 1'b0; d_src_b = 1'b1; d_wb = 2'd1; d_mr = 1'b1; d_rw = 1'b1; use1 = 1'b1;
      end
      7'h23: if (f3 < 3'd3) begin
        d_illegal = 1'b0; d_src_b = 1'b1; d_imm = 3'd1; d_mw = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      7'h13: if (f3 == 3'd1 ? f7 == 7'h00 : (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
        d_illegal = 1'b0; d_src_b = 1'b1; d_rw = 1'b1; use1 = 1'b1;
        d_alu = alu_of(f3, f3 == 3'd5 && f7[5]);
      end
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        d_illegal = 1'b0; d_rw = 1'b1; use1 = 1'b1; use2 = 1'b1; d_alu = alu_of(f3, f7[5]);
      end else if (ENABLE_M && f7 == 7'h01) begin
        d_illegal = 1'b0; d_rw = 1'b1; use1 = 1'b1; use2 = 1'b1; d_alu = ALU_MUL + 5'(f3);
      end
      7'h37: begin
        d_illegal = 1'b0; d_imm = 3'd3; d_src_a = 2'd2; d_src_b = 1'b1; d_alu = ALU_PASS_B; d_rw = 1'b1;
      end
      7'h17: begin
        d_illegal = 1'b0; d_imm = 3'd3; d_src_a = 2'd1; d_src_b = 1'b1; d_rw = 1'b1;
      end
      7'h6F: begin
        d_illegal = 1'b0; d_imm = 3'd4; d_src_a = 2'd1; d_src_b = 1'b1; d_wb = 2'd2; d_rw = 1'b1;
      end
      7'h67: if (f3 == 3'd0) begin
        d_illegal = 1'b0; d_src_b = 1'b1; d_wb = 2'd2; d_rw = 1'b1; use1 = 1'b1;
      end
      7'h63: if (f3 != 3'd2 && f3 != 3'd3) begin
        d_illegal = 1'b0; d_imm = 3'd2; d_src_a = 2'd1; d_src_b = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      // the immediate CSR forms carry zimm in the rs1 field, so they read no register
      7'h73: if (ENABLE_CSR && f3[1:0] != 2'd0 && !csr_illegal_access) begin
        d_illegal = 1'b0; d_wb = 2'd3; d_rw = 1'b1; use1 = !f3[2];
        d_src_a = f3[2] ? 2'd2 : 2'd0;
        d_cw = !(f3[1] && rs1 == 5'd0);
      end
      default: ;
    endcase
    if (rd == 5'd0) d_rw = 1'b0;
  end
  assign hazard = ex_valid && ex_mem_read_en && ex_rd != 5'd0 &&
                  ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
  assign id_ready = !rst && (!ex_valid || ex_ready) && state == RUN && !hazard;
  assign accept = id_valid && id_ready;
  assign is_div = !d_illegal && d_alu >= ALU_DIV;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      cnt             <= '0;
      ex_valid        <= 1'b0;
      ex_alu_op       <= '0;
      ex_src_a_sel    <= '0;
      ex_src_b_sel    <= 1'b0;
      ex_imm_sel      <= '0;
      ex_wb_sel       <= '0;
      ex_reg_write_en <= 1'b0;
      ex_mem_read_en  <= 1'b0;
      ex_mem_write_en <= 1'b0;
      ex_csr_write_en <= 1'b0;
      ex_rd           <= '0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      ex_csr_addr     <= '0;
      ex_illegal      <= 1'b0;
    end else if (flush) begin
      state    <= RUN;
      cnt      <= '0;
      ex_valid <= 1'b0;
    end else if (state == MD_BUSY) begin
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1) state <= RUN;
    end else if (accept) begin
      ex_valid        <= 1'b1;
      ex_alu_op       <= d_alu;
      ex_src_a_sel    <= d_src_a;
      ex_src_b_sel    <= d_src_b;
      ex_imm_sel      <= d_imm;
      ex_wb_sel       <= d_wb;
      ex_reg_write_en <= d_rw;
      ex_mem_read_en  <= d_mr;
      ex_mem_write_en <= d_mw;
      ex_csr_write_en <= d_cw;
      ex_rd           <= rd;
      ex_rs1          <= rs1;
      ex_rs2          <= rs2;
      ex_csr_addr     <= id_instr[31:20];
      ex_illegal      <= d_illegal;
      if (is_div) begin
        cnt <= DIV_LOAD;
        if (DIV_LOAD != 6'd0) state <= MD_BUSY;
      end
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pl_rv32_decode_stage.sv
// tb_pl_rv32_decode_stage: directed checks of decode, stall, divide occupancy, flush and reset
module tb_pl_rv32_decode_stage;
  logic clk = 1'b0, rst, id_valid, flush, csr_illegal_access, ex_ready;
  logic [31:0] id_instr;
  logic id_ready, ex_valid, ex_src_b_sel, ex_reg_write_en, ex_mem_read_en, ex_mem_write_en, ex_csr_write_en, ex_illegal;
  logic [4:0] ex_alu_op, ex_rd, ex_rs1, ex_rs2;
  logic [1:0] ex_src_a_sel, ex_wb_sel;
  logic [2:0] ex_imm_sel;
  logic [11:0] ex_csr_addr;
  logic nm_id_ready, nm_ex_valid, nm_src_b_sel, nm_reg_write_en, nm_mem_read_en, nm_mem_write_en, nm_csr_write_en, nm_illegal;
  logic [4:0] nm_alu_op, nm_rd, nm_rs1, nm_rs2;
  logic [1:0] nm_src_a_sel, nm_wb_sel;
  logic [2:0] nm_imm_sel;
  logic [11:0] nm_csr_addr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pl_rv32_decode_stage #(.ENABLE_M(1'b1), .DIV_CYCLES(4), .ENABLE_CSR(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .flush(flush),
    .csr_illegal_access(csr_illegal_access), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_src_a_sel(ex_src_a_sel), .ex_src_b_sel(ex_src_b_sel), .ex_imm_sel(ex_imm_sel), .ex_wb_sel(ex_wb_sel),
    .ex_reg_write_en(ex_reg_write_en), .ex_mem_read_en(ex_mem_read_en), .ex_mem_write_en(ex_mem_write_en),
    .ex_csr_write_en(ex_csr_write_en), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_csr_addr(ex_csr_addr), .ex_illegal(ex_illegal));
  pl_rv32_decode_stage #(.ENABLE_M(1'b0), .DIV_CYCLES(4), .ENABLE_CSR(1'b1)) dut_nm (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(nm_id_ready), .id_instr(id_instr), .flush(flush),
    .csr_illegal_access(csr_illegal_access), .ex_ready(ex_ready), .ex_valid(nm_ex_valid), .ex_alu_op(nm_alu_op),
    .ex_src_a_sel(nm_src_a_sel), .ex_src_b_sel(nm_src_b_sel), .ex_imm_sel(nm_imm_sel), .ex_wb_sel(nm_wb_sel),
    .ex_reg_write_en(nm_reg_write_en), .ex_mem_read_en(nm_mem_read_en), .ex_mem_write_en(nm_mem_write_en),
    .ex_csr_write_en(nm_csr_write_en), .ex_rd(nm_rd), .ex_rs1(nm_rs1), .ex_rs2(nm_rs2),
    .ex_csr_addr(nm_csr_addr), .ex_illegal(nm_illegal));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'h0; flush = 1'b0; csr_illegal_access = 1'b0; ex_ready = 1'b0;
    tick; tick;
    chk("rst_valid", ex_valid, 0);
    chk("rst_ready", id_ready, 0);
    chk("rst_alu", ex_alu_op, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_rw", ex_reg_write_en, 0);
    rst = 1'b0; ex_ready = 1'b1;
    #1 chk("ready_after_rst", id_ready, 1);
    id_valid = 1'b1; id_instr = 32'h00500093;
    tick;
    chk("addi_valid", ex_valid, 1);
    chk("addi_alu", ex_alu_op, 0);
    chk("addi_srcb", ex_src_b_sel, 1);
    chk("addi_imm", ex_imm_sel, 0);
    chk("addi_rw", ex_reg_write_en, 1);
    chk("addi_rd", ex_rd, 1);
    chk("addi_ill", ex_illegal, 0);
    id_instr = 32'h402081B3;
    tick;
    chk("sub_alu", ex_alu_op, 1);
    chk("sub_srcb", ex_src_b_sel, 0);
    chk("sub_rd", ex_rd, 3);
    id_instr = 32'h002081B3;
    tick;
    chk("add_alu", ex_alu_op, 0);
    chk("add_rs2", ex_rs2, 2);
    ex_ready = 1'b0; id_instr = 32'h12345137;
    #1 chk("hold_ready", id_ready, 0);
    tick;
    chk("hold_valid", ex_valid, 1);
    chk("hold_rd", ex_rd, 3);
    chk("hold_alu", ex_alu_op, 0);
    ex_ready = 1'b1;
    tick;
    chk("lui_alu", ex_alu_op, 10);
    chk("lui_imm", ex_imm_sel, 3);
    chk("lui_rd", ex_rd, 2);
    id_instr = 32'h000000EF;
    tick;
    chk("jal_wb", ex_wb_sel, 2);
    chk("jal_srca", ex_src_a_sel, 1);
    chk("jal_imm", ex_imm_sel, 4);
    id_instr = 32'h00208063;
    tick;
    chk("beq_imm", ex_imm_sel, 2);
    chk("beq_rw", ex_reg_write_en, 0);
    chk("beq_srca", ex_src_a_sel, 1);
    id_instr = 32'h0020A023;
    tick;
    chk("sw_mw", ex_mem_write_en, 1);
    chk("sw_imm", ex_imm_sel, 1);
    chk("sw_rw", ex_reg_write_en, 0);
    id_instr = 32'h0000A283;
    tick;
    chk("lw_mr", ex_mem_read_en, 1);
    chk("lw_wb", ex_wb_sel, 1);
    chk("lw_rd", ex_rd, 5);
    id_instr = 32'h00528333;
    #1 chk("hazard_ready", id_ready, 0);
    tick;
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_ready", id_ready, 1);
    tick;
    chk("after_bubble_valid", ex_valid, 1);
    chk("after_bubble_rd", ex_rd, 6);
    id_instr = 32'h0220C3B3;
    tick;
    id_valid = 1'b0;
    chk("div_alu", ex_alu_op, 15);
    chk("div_rd", ex_rd, 7);
    chk("nm_div_ill", nm_illegal, 1);
    chk("nm_div_rw", nm_reg_write_en, 0);
    chk("div_v0", ex_valid, 1);
    chk("div_r0", id_ready, 0);
    tick;
    chk("div_v1", ex_valid, 1);
    chk("div_r1", id_ready, 0);
    tick;
    chk("div_v2", ex_valid, 1);
    chk("div_r2", id_ready, 0);
    tick;
    chk("div_v3", ex_valid, 1);
    chk("div_r3", id_ready, 1);
    tick;
    chk("div_done", ex_valid, 0);
    id_valid = 1'b1; id_instr = 32'h022083B3;
    tick;
    chk("mul_alu", ex_alu_op, 11);
    chk("mul_ready", id_ready, 1);
    id_instr = 32'h0220C3B3;
    tick;
    chk("div2_ready", id_ready, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0; id_valid = 1'b0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_ready", id_ready, 1);
    id_valid = 1'b1; id_instr = 32'h00500093; flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_discard", ex_valid, 0);
    id_instr = 32'h00100013;
    tick;
    chk("x0_valid", ex_valid, 1);
    chk("x0_rw", ex_reg_write_en, 0);
    id_instr = 32'h300020F3;
    tick;
    chk("csrrs_cw", ex_csr_write_en, 0);
    chk("csrrs_wb", ex_wb_sel, 3);
    chk("csrrs_addr", ex_csr_addr, 12'h300);
    chk("csrrs_rw", ex_reg_write_en, 1);
    id_instr = 32'h300110F3; csr_illegal_access = 1'b1;
    tick;
    csr_illegal_access = 1'b0;
    chk("csr_acc_ill", ex_illegal, 1);
    chk("csr_acc_cw", ex_csr_write_en, 0);
    chk("csr_acc_rw", ex_reg_write_en, 0);
    id_instr = 32'h300110F3;
    tick;
    chk("csrrw_cw", ex_csr_write_en, 1);
    rst = 1'b1;
    tick;
    chk("midrst_valid", ex_valid, 0);
    chk("midrst_ready", id_ready, 0);
    chk("midrst_wb", ex_wb_sel, 0);
    chk("midrst_addr", ex_csr_addr, 0);
    chk("midrst_rd", ex_rd, 0);
    rst = 1'b0; id_valid = 1'b0;
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
